// File: rtl/ekf_stage_sequencer_pkg.sv
// ekf_stage_sequencer_pkg
//   Shared EKF definitions: stage request/completion codes, sticky error
//   encodings, sequencer state encodings and a stage-code legality helper.
//   Imported by the sequencer and by the top level that hosts it.
package ekf_stage_sequencer_pkg;

  // Stage codes carried on stage_val / stage_rdy and stored in the program.
  typedef enum logic [2:0] {
    STG_IDLE  = 3'b000,
    STG_PRD   = 3'b001,
    STG_NEW   = 3'b010,
    STG_UPD   = 3'b011,
    STG_ASSOC = 3'b100
  } stage_code_t;

  // Sticky error codes reported on err.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ILLEGAL = 2'b10
  } err_code_t;

  // Sequencer state encodings (kept as plain constants for legacy tools).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  // True for a code that names a real EKF stage (PRD..ASSOC).
  function automatic logic is_stage_code(input logic [2:0] code);
    return (code >= STG_PRD) && (code <= STG_ASSOC);
  endfunction

endpackage

// File: rtl/ekf_cycle_counter.sv
// ekf_cycle_counter
//   Up-counter with synchronous clear and count enable, plus a terminal-count
//   compare against a run-time limit.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (count -> 0)
//     clear  - synchronous clear, wins over enable
//     enable - increment the count this cycle
//     limit  - terminal count value
//     tc     - high while the count equals limit
module ekf_cycle_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/ekf_stage_sequencer.sv
// ekf_stage_sequencer
//   Walks a small program of EKF stage codes: issues each stage to the EKF
//   core as a fixed-width stage_val pulse, waits for the matching stage_rdy
//   completion (with optional timeout), then advances. A 000 entry ends the
//   program early; codes above ASSOC abort the run with an error.
//   Ports:
//     clk       - rising-edge clock
//     sys_rst_n - asynchronous active-low reset
//     start     - one-cycle run request, honoured only when idle
//     abort     - level, returns to idle from any state without done
//     loop_en   - restart at step 0 after the last step instead of finishing
//     prog      - 3 bits per step, step i at prog[3i+2:3i]
//     stage_val - stage request to the EKF core (000 when not issuing)
//     stage_rdy - completion code from the EKF core
//     busy      - high whenever not idle
//     done      - one-cycle pulse on normal completion
//     err       - sticky error code, cleared by the next accepted start
//     step_idx  - index of the step being issued or awaited
module ekf_stage_sequencer
  import ekf_stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STEPS     = 4,
  parameter int unsigned VAL_PULSE_CYC = 2,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       sys_rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       loop_en,
  input  logic [3*NUM_STEPS-1:0]     prog,
  output logic [2:0]                 stage_val,
  input  logic [2:0]                 stage_rdy,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 err,
  output logic [$clog2(NUM_STEPS):0] step_idx
);

  localparam int unsigned          IDX_W        = $clog2(NUM_STEPS) + 1;
  localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(NUM_STEPS - 1);
  localparam logic [3:0]           PULSE_LAST   = 4'(VAL_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic                 TIMEOUT_EN   = (TIMEOUT_CYC != 0);

  logic [2:0] state;
  logic       val_on;     // stage_val pulse in progress (second phase of ISSUE)
  logic       end_flag;   // current step held a 000 end-of-program marker
  logic [2:0] issued;     // code awaited in WAIT
  logic [2:0] cur_code;
  logic       pulse_last;
  logic       wait_last;

  always_comb begin
    cur_code = STG_IDLE;
    for (int unsigned i = 0; i < NUM_STEPS; i++) begin
      if (step_idx == IDX_W'(i)) begin
        cur_code = prog[3*i +: 3];
      end
    end
  end

  // Counts the cycles stage_val has been driven for the current issue.
  ekf_cycle_counter #(.W(4)) u_pulse_cnt (
    .clk    (clk),
    .rst_n  (sys_rst_n),
    .clear  (!val_on),
    .enable (val_on),
    .limit  (PULSE_LAST),
    .tc     (pulse_last)
  );

  // Counts cycles spent in WAIT; zero on the first WAIT cycle.
  ekf_cycle_counter #(.W(CNT_W)) u_wait_cnt (
    .clk    (clk),
    .rst_n  (sys_rst_n),
    .clear  (state != ST_WAIT),
    .enable (state == ST_WAIT),
    .limit  (TIMEOUT_LAST),
    .tc     (wait_last)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      stage_val <= STG_IDLE;
      done      <= 1'b0;
      err       <= ERR_NONE;
      step_idx  <= '0;
      val_on    <= 1'b0;
      end_flag  <= 1'b0;
      issued    <= STG_IDLE;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= ST_IDLE;
        stage_val <= STG_IDLE;
        val_on    <= 1'b0;
        end_flag  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              step_idx <= '0;
              err      <= ERR_NONE;
              end_flag <= 1'b0;
              state    <= ST_ISSUE;
            end
          end
          // First ISSUE cycle decodes the step; stage_val then runs for
          // VAL_PULSE_CYC cycles. stage_rdy is deliberately not looked at here.
          ST_ISSUE: begin
            if (val_on) begin
              if (pulse_last) begin
                stage_val <= STG_IDLE;
                val_on    <= 1'b0;
                state     <= ST_WAIT;
              end
            end else if (cur_code == STG_IDLE) begin
              end_flag <= 1'b1;
              state    <= ST_NEXT;
            end else if (!is_stage_code(cur_code)) begin
              err   <= ERR_ILLEGAL;
              state <= ST_FAIL;
            end else begin
              stage_val <= cur_code;
              issued    <= cur_code;
              val_on    <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (stage_rdy == issued) begin
              state <= ST_NEXT;
            end else if (TIMEOUT_EN && wait_last) begin
              err   <= ERR_TIMEOUT;
              state <= ST_FAIL;
            end
          end
          ST_NEXT: begin
            end_flag <= 1'b0;
            if (step_idx == LAST_IDX || end_flag) begin
              // An empty program (marker at step 0) finishes even when looping.
              if (loop_en && !(end_flag && step_idx == '0)) begin
                step_idx <= '0;
                state    <= ST_ISSUE;
              end else begin
                done  <= 1'b1;
                state <= ST_IDLE;
              end
            end else begin
              step_idx <= step_idx + 1'b1;
              state    <= ST_ISSUE;
            end
          end
          ST_FAIL: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ekf_stage_sequencer.sv
// tb_ekf_stage_sequencer
//   Self-checking bench for ekf_stage_sequencer. A program-level reference
//   model derives the expected issue list, end status and cycle timing from
//   the program contents; a cycle loop drives start/stage_rdy/abort and
//   records what the sequencer actually does.
module tb_ekf_stage_sequencer;
  import ekf_stage_sequencer_pkg::*;

  localparam int unsigned P  = 2;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic        abort;
  logic        loop_en;
  logic [11:0] prog;
  logic [2:0]  stage_val;
  logic [2:0]  stage_rdy;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [2:0]  step_idx;

  int checks   = 0;
  int failures = 0;

  int exp_code[$];
  int exp_extra[$];
  int exp_err;
  int exp_done;
  int exp_tail;

  ekf_stage_sequencer #(
    .NUM_STEPS     (4),
    .VAL_PULSE_CYC (P),
    .TIMEOUT_CYC   (TO),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .abort     (abort),
    .loop_en   (loop_en),
    .prog      (prog),
    .stage_val (stage_val),
    .stage_rdy (stage_rdy),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rand_code();
    int r;
    r = int'($urandom_range(9, 0));
    if (r == 0) return 3'd0;
    if (r == 1) return 3'(int'($urandom_range(7, 5)));
    return 3'(int'($urandom_range(4, 1)));
  endfunction

  // Program-level reference: which stages get issued, in what order, how
  // many end markers are skipped before each, and how the run ends.
  task automatic build_model(input logic [11:0] p, input bit lp, input int limit,
                             input bit no_rdy);
    int i;
    int extra;
    int c;
    i = 0;
    extra = 0;
    exp_code.delete();
    exp_extra.delete();
    exp_err = 0;
    exp_done = 0;
    exp_tail = 0;
    while (exp_code.size() < limit) begin
      c = int'(p[3*i +: 3]);
      if (c == 0) begin
        if (!lp || i == 0) begin
          exp_done = 1;
          exp_tail = 2;
          break;
        end
        extra += 2;
        i = 0;
      end else if (c > 4) begin
        exp_err = 2;
        break;
      end else begin
        exp_code.push_back(c);
        exp_extra.push_back(extra);
        extra = 0;
        if (i == 3) begin
          if (!lp) begin
            exp_done = 1;
            break;
          end
          i = 0;
        end else begin
          i++;
        end
      end
    end
    if (no_rdy && exp_code.size() > 0) begin
      while (exp_code.size() > 1) void'(exp_code.pop_back());
      exp_err = 1;
      exp_done = 0;
    end
  endtask

  task automatic run_case(input string name, input logic [11:0] p, input bit lp,
                          input int limit, input bit no_rdy, input bit early,
                          input int fixed_d, input bit noise);
    int st[$];
    int wd[$];
    int dl[$];
    int cq[$];
    int cyc, d, rdy_at, dones, err_cyc, fall_cyc, abort_cyc, val_cnt, n;
    int err_final, val_at_fall;
    logic [2:0] prev;
    bit finished;

    build_model(p, lp, limit, no_rdy);
    prog = p;
    loop_en = lp;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rdy_at = -1; dones = 0; err_cyc = -1; fall_cyc = -1; abort_cyc = -1;
    val_cnt = 0; prev = 3'd0; finished = 1'b0; err_final = -1; val_at_fall = -1;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (stage_val != 3'd0 && prev == 3'd0) begin
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(25, P));
        st.push_back(cyc);
        cq.push_back(int'(stage_val));
        dl.push_back(d);
        val_cnt = 0;
        if (lp && st.size() == limit) abort_cyc = cyc + int'(P) + 1;
        else if (!no_rdy) rdy_at = cyc + d;
      end
      if (stage_val != 3'd0) val_cnt++;
      if (stage_val == 3'd0 && prev != 3'd0) wd.push_back(val_cnt);
      if (done) dones++;
      if (err != 2'd0 && err_cyc < 0) err_cyc = cyc;
      if (!busy) begin
        fall_cyc = cyc;
        err_final = int'(err);
        val_at_fall = int'(stage_val);
        finished = 1'b1;
        break;
      end
      prev = stage_val;
      if (cyc == rdy_at) stage_rdy = 3'(cq[$]);
      else if (early && stage_val != 3'd0) stage_rdy = stage_val;
      else stage_rdy = 3'd0;
      abort = (cyc == abort_cyc);
      start = noise && ($urandom_range(3, 0) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    stage_rdy = 3'd0;
    abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end

    check({name, ".finished"}, int'(finished), 1);
    check({name, ".issues"}, st.size(), exp_code.size());
    n = (st.size() < exp_code.size()) ? st.size() : exp_code.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s.code%0d", name, k), cq[k], exp_code[k]);
      check($sformatf("%s.width%0d", name, k), (k < wd.size()) ? wd[k] : -1, int'(P));
      if (k > 0)
        check($sformatf("%s.gap%0d", name, k), st[k] - st[k-1], dl[k-1] + 3 + exp_extra[k]);
    end
    check({name, ".done_count"}, dones, exp_done);
    check({name, ".err"}, err_final, exp_err);
    if (exp_done == 1 && n > 0 && n == st.size())
      check({name, ".done_time"}, fall_cyc - st[n-1], dl[n-1] + 2 + exp_tail);
    if (exp_done == 1 && exp_code.size() == 0)
      check({name, ".empty_time"}, fall_cyc, 2);
    if (exp_err == 2) begin
      check({name, ".illegal_time"}, err_cyc, (n > 0) ? st[n-1] + dl[n-1] + 3 : 1);
      check({name, ".fail_len"}, fall_cyc - err_cyc, 1);
      if (!lp) check({name, ".fail_idx"}, int'(step_idx), exp_code.size());
    end
    if (exp_err == 1 && n > 0) begin
      check({name, ".timeout_time"}, err_cyc - st[0], int'(P + TO));
      check({name, ".fail_len"}, fall_cyc - err_cyc, 1);
    end
    if (lp && exp_code.size() == limit) begin
      check({name, ".abort_lat"}, fall_cyc - abort_cyc, 1);
      check({name, ".abort_val"}, val_at_fall, 0);
    end
  endtask

  initial begin
    int prev_v;
    int rdy_at;
    bit ok;
    logic [11:0] rp;
    bit rl;

    sys_rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    loop_en = 1'b0;
    prog = '0;
    stage_rdy = 3'd0;
    #1;
    check("rst.stage_val", int'(stage_val), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.err", int'(err), 0);
    check("rst.step_idx", int'(step_idx), 0);
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);

    run_case("all4", {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 99, 1'b0, 1'b0, 20, 1'b0);
    run_case("minlat", {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0, 99, 1'b0, 1'b0, int'(P), 1'b0);
    run_case("assoc_end", {rand_code(), rand_code(), 3'd0, 3'd4}, 1'b0, 99, 1'b0, 1'b0, 0, 1'b1);
    run_case("timeout", {rand_code(), rand_code(), rand_code(), 3'd1}, 1'b0, 99, 1'b1, 1'b0, 0, 1'b0);
    run_case("illegal", {rand_code(), rand_code(), 3'd5, 3'd1}, 1'b0, 99, 1'b0, 1'b0, 0, 1'b0);

    // Sticky error survives idle but not reset.
    check("sticky.err", int'(err), 2);
    sys_rst_n = 1'b0;
    #1;
    check("rst_idle.err", int'(err), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;

    run_case("loop", {3'd0, 3'd0, 3'd3, 3'd1}, 1'b1, 6, 1'b0, 1'b0, 0, 1'b0);

    // Reset while waiting on step 1.
    prog = {3'd4, 3'd3, 3'd2, 3'd1};
    loop_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev_v = 0;
    rdy_at = -1;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      stage_rdy = 3'd0;
      if (stage_val == 3'd1 && prev_v == 0) rdy_at = c + int'(P);
      if (c == rdy_at) stage_rdy = 3'd1;
      if (stage_val == 3'd0 && prev_v == 2) begin
        ok = 1'b1;
        break;
      end
      prev_v = int'(stage_val);
      @(negedge clk);
    end
    stage_rdy = 3'd0;
    check("midwait.reached", int'(ok), 1);
    check("midwait.step_idx", int'(step_idx), 1);
    check("midwait.busy", int'(busy), 1);
    sys_rst_n = 1'b0;
    #1;
    check("midrst.stage_val", int'(stage_val), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.err", int'(err), 0);
    check("midrst.step_idx", int'(step_idx), 0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("postrst.busy", int'(busy), 0);
    check("postrst.stage_val", int'(stage_val), 0);

    run_case("early_rdy", {3'd0, 3'd0, 3'd0, 3'd3}, 1'b0, 99, 1'b0, 1'b1, 15, 1'b0);

    for (int r = 0; r < 12; r++) begin
      rp = {rand_code(), rand_code(), rand_code(), rand_code()};
      rl = ($urandom_range(3, 0) == 0);
      run_case($sformatf("rnd%0d", r), rp, rl, rl ? 5 : 99, 1'b0, 1'b0, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ekf_stage_sequencer.md
EKF_STAGE_SEQUENCER -- requirements
Module: ekf_stage_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 4; number of entries in the stage program.
REQ-002 Parameter VAL_PULSE_CYC, default 2; cycles stage_val is held per issue, legal range 1..15.
REQ-003 Parameter TIMEOUT_CYC, default 4096; maximum cycles to wait for stage_rdy per step; 0 disables the timeout.
REQ-004 Parameter CNT_W, default 16; width of the wait and timeout counters, SHALL satisfy 2^CNT_W > TIMEOUT_CYC.
REQ-005 clk  input  1  single system clock, rising edge.
REQ-006 sys_rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle request to run the program, sampled only in IDLE.
REQ-008 abort  input  1  level; forces return to IDLE from any state.
REQ-009 loop_en  input  1  when high, the program restarts at step 0 after the last step instead of finishing.
REQ-010 prog  input  3*NUM_STEPS  stage codes; step i is prog[3i+2:3i]; held stable while busy.
REQ-011 stage_val  output  3  stage request to the EKF core (000 idle, 001 PRD, 010 NEW, 011 UPD, 100 ASSOC).
REQ-012 stage_rdy  input  3  completion code from the EKF core; nonzero for one or more cycles when a stage finishes.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the program completes normally.
REQ-015 err  output  2  sticky error code: 00 none, 01 timeout, 10 illegal code; cleared on the next accepted start.
REQ-016 step_idx  output  $clog2(NUM_STEPS)+1  index of the step currently issued or awaited.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT, NEXT and FAIL.
REQ-018 IDLE: start=1 SHALL set step_idx=0, clear err and go to ISSUE on the next edge.
REQ-019 ISSUE: if prog[step_idx]==000, the block SHALL treat this as the end of program and go to NEXT with the end flag set, without driving stage_val.
REQ-020 ISSUE: a code >100 SHALL set err=10 and go to FAIL without driving stage_val.
REQ-021 ISSUE: a legal nonzero code SHALL drive stage_val=code for exactly VAL_PULSE_CYC consecutive cycles, then go to WAIT with stage_val=000.
REQ-022 WAIT: stage_rdy equal to the issued code SHALL go to NEXT on the next edge; any other nonzero stage_rdy is ignored.
REQ-023 WAIT: the wait counter SHALL increment each cycle; reaching TIMEOUT_CYC (if nonzero) SHALL set err=01 and go to FAIL.
REQ-024 stage_rdy SHALL be ignored in ISSUE, so a stale completion from the previous step cannot retire the current step.
REQ-025 NEXT: if step_idx==NUM_STEPS-1 or the end flag is set, then with loop_en=1 the block SHALL wrap step_idx to 0 and go to ISSUE; otherwise it SHALL pulse done for one cycle and go to IDLE.
REQ-026 NEXT: in all other cases the block SHALL increment step_idx and go to ISSUE; NEXT SHALL last one cycle.
REQ-027 If the end flag occurs at step 0 with loop_en=1, the block SHALL pulse done and go to IDLE instead of spinning.
REQ-028 FAIL SHALL hold busy=1 with stage_val=000 for one cycle, then go to IDLE; err SHALL stay set.
REQ-029 abort=1 SHALL take precedence over every other transition: the next state is IDLE, stage_val=000, and no done pulse is produced; err is unchanged.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 Issue-to-issue latency: the minimum time from the first stage_val cycle of step i to the first stage_val cycle of step i+1 SHALL be VAL_PULSE_CYC+3 cycles, assuming stage_rdy arrives in the first WAIT cycle.

Reset
REQ-032 sys_rst_n=0 SHALL asynchronously force state=IDLE, stage_val=000, busy=0, done=0, err=00, step_idx=0, and clear all counters.
REQ-033 Reset asserted in mid-program SHALL abandon the program; after release the block SHALL stay in IDLE until the next start.

Structure
REQ-034 The stage codes (IDLE, PRD, NEW, UPD, ASSOC) and the err encodings SHALL live in the shared EKF package and be used by both this block and Top.
REQ-035 The pulse/timeout counter SHALL be a single sub-module, ekf_cycle_counter (clear, enable, terminal-count compare), instantiated twice.
REQ-036 The sequencer's stage_val and stage_rdy ports SHALL connect directly to the Top ports of the same names.

Verification
REQ-037 Program PRD,NEW,UPD,ASSOC; stage_rdy echoes each code 20 cycles after the issue -> 4 issues in order, each 2 cycles wide; done pulses once; err=00.
REQ-038 Program ASSOC,000,x,x -> one ASSOC issue, then done; steps 2-3 are never issued.
REQ-039 Program PRD with no stage_rdy and TIMEOUT_CYC=64 -> err=01 after 64 WAIT cycles; busy falls one cycle later; no done pulse.
REQ-040 Program containing code 101 at step 1 -> step 0 completes, then err=10 with no stage_val at step 1.
REQ-041 loop_en=1 with program PRD,UPD,000,000 -> the sequence PRD,UPD,PRD,UPD... repeats; abort then clears busy in 1 cycle with stage_val=000.
REQ-042 Reset pulse during WAIT, and stage_rdy=011 arriving during ISSUE of UPD -> all outputs reach their reset values; the early stage_rdy does not retire the step.
